// File: rtl/cdb_rr_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cdb_rr_scheduler_pkg                                            |
// | Purpose  : Shared widths and source encoding for the CDB scheduler slice.  |
// |            ROB_ID_WIDTH  - ROB tag width                                   |
// |            REG_BUS       - result value width                              |
// |            INST_ADDR_BUS - branch target width                             |
// |            cdb_src_e     - SRC_ALU=0 / SRC_LSB=1                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package cdb_rr_scheduler_pkg;

   localparam int ROB_ID_WIDTH  = 4;
   localparam int REG_BUS       = 32;
   localparam int INST_ADDR_BUS = 32;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSB = 1'b1
   } cdb_src_e;

   function automatic cdb_src_e other_src(input cdb_src_e src);
      return (src == SRC_ALU) ? SRC_LSB : SRC_ALU;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_rr_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cdb_rr_scheduler_if                                             |
// | Purpose  : Producer handshakes (ALU, LSB) and the CDB broadcast bundle.    |
// |            master : producer/consumer side (drives alu_*/lsb_* requests)   |
// |            slave  : scheduler side (drives readies and cdb_*)              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface cdb_rr_scheduler_if
   import cdb_rr_scheduler_pkg::*;
#(
   parameter int ROB_W  = ROB_ID_WIDTH,
   parameter int DATA_W = REG_BUS,
   parameter int ADDR_W = INST_ADDR_BUS
) ();

   logic              alu_valid;
   logic              alu_ready;
   logic [ROB_W-1:0]  alu_rob_id;
   logic [DATA_W-1:0] alu_value;
   logic [ADDR_W-1:0] alu_addr;
   logic              alu_branch_outcome;

   logic              lsb_valid;
   logic              lsb_ready;
   logic [ROB_W-1:0]  lsb_rob_id;
   logic [DATA_W-1:0] lsb_value;

   logic              cdb_valid;
   logic [ROB_W-1:0]  cdb_rob_id;
   logic [DATA_W-1:0] cdb_value;
   logic [ADDR_W-1:0] cdb_addr;
   logic              cdb_branch_outcome;
   logic              cdb_src;

   modport master (
      output alu_valid, alu_rob_id, alu_value, alu_addr, alu_branch_outcome,
      output lsb_valid, lsb_rob_id, lsb_value,
      input  alu_ready, lsb_ready,
      input  cdb_valid, cdb_rob_id, cdb_value, cdb_addr, cdb_branch_outcome, cdb_src
   );

   modport slave (
      input  alu_valid, alu_rob_id, alu_value, alu_addr, alu_branch_outcome,
      input  lsb_valid, lsb_rob_id, lsb_value,
      output alu_ready, lsb_ready,
      output cdb_valid, cdb_rob_id, cdb_value, cdb_addr, cdb_branch_outcome, cdb_src
   );

endinterface
`default_nettype wire

// File: rtl/cdb_src_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cdb_src_fifo                                                    |
// | Purpose  : Small synchronous FIFO buffering one producer's results.        |
// |            clk/rst/flush - clock, sync reset, sync discard-all             |
// |            push/push_data - write (caller guarantees not full)             |
// |            pop            - read  (caller guarantees not empty)            |
// |            head_data/count/full/empty - registered-state status            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cdb_src_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] c_full_count = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   // Storage carries no reset: stale words are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign head_data = r_mem[r_rd_ptr];
   assign count     = r_count;
   assign full      = (r_count == c_full_count);
   assign empty     = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/cdb_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cdb_rr_scheduler                                                |
// | Purpose  : Buffers ALU and LSB results and broadcasts one per cycle on a   |
// |            registered CDB, round-robin between the two FIFO heads.         |
// |            clk/rst - clock, synchronous active-high reset                  |
// |            flush   - discards buffered results and the CDB stage           |
// |            bus     - producer handshakes and CDB outputs (slave modport)   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cdb_rr_scheduler
   import cdb_rr_scheduler_pkg::*;
#(
   parameter int ROB_W  = ROB_ID_WIDTH,
   parameter int DATA_W = REG_BUS,
   parameter int ADDR_W = INST_ADDR_BUS,
   parameter int DEPTH  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   cdb_rr_scheduler_if.slave  bus
);

   localparam int ALU_W = ROB_W + DATA_W + ADDR_W + 1;
   localparam int LSB_W = ROB_W + DATA_W;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

   logic             w_alu_push, w_alu_pop, w_alu_full, w_alu_empty;
   logic [ALU_W-1:0] w_alu_head;
   logic [CNT_W-1:0] w_alu_count;
   logic             w_lsb_push, w_lsb_pop, w_lsb_full, w_lsb_empty;
   logic [LSB_W-1:0] w_lsb_head;
   logic [CNT_W-1:0] w_lsb_count;

   logic [ROB_W-1:0]  w_alu_head_rob, w_lsb_head_rob;
   logic [DATA_W-1:0] w_alu_head_value, w_lsb_head_value;
   logic [ADDR_W-1:0] w_alu_head_addr;
   logic              w_alu_head_br;

   logic              w_grant;
   cdb_src_e          w_grant_src;
   cdb_src_e          w_rr_prio_next;
   cdb_src_e          r_rr_prio;

   logic              r_cdb_valid;
   logic [ROB_W-1:0]  r_cdb_rob_id;
   logic [DATA_W-1:0] r_cdb_value;
   logic [ADDR_W-1:0] r_cdb_addr;
   logic              r_cdb_branch_outcome;
   cdb_src_e          r_cdb_src;

   // Ready looks only at registered occupancy, so a same-cycle pop never
   // opens a slot for a push into a full FIFO.
   assign bus.alu_ready = (w_alu_count < c_depth) && !flush;
   assign bus.lsb_ready = (w_lsb_count < c_depth) && !flush;
   assign w_alu_push    = bus.alu_valid && bus.alu_ready;
   assign w_lsb_push    = bus.lsb_valid && bus.lsb_ready;

   cdb_src_fifo #(.WIDTH(ALU_W), .DEPTH(DEPTH)) u_alu_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (w_alu_push),
      .push_data ({bus.alu_rob_id, bus.alu_value, bus.alu_addr, bus.alu_branch_outcome}),
      .pop       (w_alu_pop),
      .head_data (w_alu_head),
      .count     (w_alu_count),
      .full      (w_alu_full),
      .empty     (w_alu_empty)
   );

   cdb_src_fifo #(.WIDTH(LSB_W), .DEPTH(DEPTH)) u_lsb_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (w_lsb_push),
      .push_data ({bus.lsb_rob_id, bus.lsb_value}),
      .pop       (w_lsb_pop),
      .head_data (w_lsb_head),
      .count     (w_lsb_count),
      .full      (w_lsb_full),
      .empty     (w_lsb_empty)
   );

   assign {w_alu_head_rob, w_alu_head_value, w_alu_head_addr, w_alu_head_br} = w_alu_head;
   assign {w_lsb_head_rob, w_lsb_head_value} = w_lsb_head;

   // Heads only: a push landing this edge is not a candidate until next cycle.
   always_comb begin
      w_grant        = 1'b0;
      w_grant_src    = SRC_ALU;
      w_rr_prio_next = r_rr_prio;
      if (!w_alu_empty && !w_lsb_empty) begin
         w_grant     = 1'b1;
         w_grant_src = r_rr_prio;
      end else if (!w_alu_empty) begin
         w_grant     = 1'b1;
         w_grant_src = SRC_ALU;
      end else if (!w_lsb_empty) begin
         w_grant     = 1'b1;
         w_grant_src = SRC_LSB;
      end
      if (w_grant) begin
         w_rr_prio_next = other_src(w_grant_src);
      end
   end

   // Pops during flush are harmless: the FIFO's flush wins.
   assign w_alu_pop = w_grant && (w_grant_src == SRC_ALU);
   assign w_lsb_pop = w_grant && (w_grant_src == SRC_LSB);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_prio            <= SRC_LSB;
         r_cdb_valid          <= 1'b0;
         r_cdb_rob_id         <= '0;
         r_cdb_value          <= '0;
         r_cdb_addr           <= '0;
         r_cdb_branch_outcome <= 1'b0;
         r_cdb_src            <= SRC_ALU;
      end else if (flush || !w_grant) begin
         // Flush leaves the round-robin pointer where it was.
         r_cdb_valid          <= 1'b0;
         r_cdb_rob_id         <= '0;
         r_cdb_value          <= '0;
         r_cdb_addr           <= '0;
         r_cdb_branch_outcome <= 1'b0;
         r_cdb_src            <= SRC_ALU;
      end else begin
         r_rr_prio   <= w_rr_prio_next;
         r_cdb_valid <= 1'b1;
         r_cdb_src   <= w_grant_src;
         if (w_grant_src == SRC_ALU) begin
            r_cdb_rob_id         <= w_alu_head_rob;
            r_cdb_value          <= w_alu_head_value;
            r_cdb_addr           <= w_alu_head_addr;
            r_cdb_branch_outcome <= w_alu_head_br;
         end else begin
            r_cdb_rob_id         <= w_lsb_head_rob;
            r_cdb_value          <= w_lsb_head_value;
            r_cdb_addr           <= '0;
            r_cdb_branch_outcome <= 1'b0;
         end
      end
   end

   assign bus.cdb_valid          = r_cdb_valid;
   assign bus.cdb_rob_id         = r_cdb_rob_id;
   assign bus.cdb_value          = r_cdb_value;
   assign bus.cdb_addr           = r_cdb_addr;
   assign bus.cdb_branch_outcome = r_cdb_branch_outcome;
   assign bus.cdb_src            = r_cdb_src;

   // A full FIFO must never see a push.
   a_no_push_full : assert property (@(posedge clk) disable iff (rst)
      !(w_alu_full && w_alu_push) && !(w_lsb_full && w_lsb_push));

endmodule
`default_nettype wire

// File: tb/tb_cdb_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cdb_rr_scheduler                                             |
// | Purpose  : Self-checking bench for cdb_rr_scheduler: directed vector       |
// |            table, hand sequences for latency/flush/wrap, and randomized    |
// |            traffic against a queue-based reference model.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cdb_rr_scheduler;
   import cdb_rr_scheduler_pkg::*;

   localparam int ROB_W    = 4;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 32;
   localparam int DEPTH    = 2;
   localparam int CDB_BITS = ROB_W + DATA_W + ADDR_W + 3;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   cdb_rr_scheduler_if #(.ROB_W(ROB_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   cdb_rr_scheduler #(.ROB_W(ROB_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ROB_W-1:0]  rob;
      logic [DATA_W-1:0] value;
      logic [ADDR_W-1:0] addr;
      logic              br;
   } ent_t;

   typedef struct {
      logic rst;
      logic flush;
      logic av;
      ent_t a;
      logic lv;
      ent_t l;
   } stim_t;

   typedef struct {
      logic v;
      ent_t e;
      logic src;
   } cdb_t;

   typedef struct {
      stim_t      s;
      logic       chk_rdy;
      logic [1:0] rdy;
      logic       ev;
      logic       esrc;
      int         erob;
   } vec_t;

   // Reference model: one queue per producer, priority bit, expected CDB.
   ent_t aq[$];
   ent_t lq[$];
   logic m_prio;
   cdb_t m_cdb;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int seen_rob[$];
   int seen_cyc[$];

   function automatic ent_t alu_ent(int r);
      ent_t e;
      e.rob   = ROB_W'(r);
      e.value = 32'hA000_0000 | 32'(r);
      e.addr  = 32'h0000_1000 + 32'(r * 4);
      e.br    = 1'(r & 1);
      return e;
   endfunction

   function automatic ent_t lsb_ent(int r);
      ent_t e;
      e.rob   = ROB_W'(r);
      e.value = 32'hB000_0000 | 32'(r);
      e.addr  = '0;
      e.br    = 1'b0;
      return e;
   endfunction

   function automatic cdb_t zero_cdb();
      cdb_t c;
      c.v = 1'b0; c.e.rob = '0; c.e.value = '0; c.e.addr = '0; c.e.br = 1'b0; c.src = 1'b0;
      return c;
   endfunction

   function automatic logic [CDB_BITS-1:0] pack_cdb(cdb_t c);
      return {c.v, c.e.rob, c.e.value, c.e.addr, c.e.br, c.src};
   endfunction

   function automatic cdb_t dut_cdb();
      cdb_t c;
      c.v       = bus.cdb_valid;
      c.e.rob   = bus.cdb_rob_id;
      c.e.value = bus.cdb_value;
      c.e.addr  = bus.cdb_addr;
      c.e.br    = bus.cdb_branch_outcome;
      c.src     = bus.cdb_src;
      return c;
   endfunction

   function automatic stim_t st(logic r, logic f, logic av, int ar, logic lv, int lr);
      stim_t s;
      s.rst = r; s.flush = f; s.av = av; s.a = alu_ent(ar); s.lv = lv; s.l = lsb_ent(lr);
      return s;
   endfunction

   function automatic vec_t mkv(stim_t s, logic chk, logic [1:0] rdy, logic ev, logic esrc, int erob);
      vec_t v;
      v.s = s; v.chk_rdy = chk; v.rdy = rdy; v.ev = ev; v.esrc = esrc; v.erob = erob;
      return v;
   endfunction

   task automatic check(input string name, input logic [CDB_BITS-1:0] act, input logic [CDB_BITS-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drives one cycle of stimulus at the falling edge, checks readiness,
   // advances the model, then checks the CDB at the next falling edge.
   task automatic cycle(input stim_t s, output logic acc_a, output logic acc_l, output logic [1:0] rdy_seen);
      logic ra, rl, has_a, has_l, g;
      ent_t e;
      rst                    = s.rst;
      flush                  = s.flush;
      bus.alu_valid          = s.av;
      bus.alu_rob_id         = s.a.rob;
      bus.alu_value          = s.a.value;
      bus.alu_addr           = s.a.addr;
      bus.alu_branch_outcome = s.a.br;
      bus.lsb_valid          = s.lv;
      bus.lsb_rob_id         = s.l.rob;
      bus.lsb_value          = s.l.value;
      #1;
      rdy_seen = {bus.alu_ready, bus.lsb_ready};
      ra = (aq.size() < DEPTH) && !s.flush;
      rl = (lq.size() < DEPTH) && !s.flush;
      if (!s.rst) check("ready", CDB_BITS'(rdy_seen), CDB_BITS'({ra, rl}));
      acc_a = !s.rst && s.av && ra;
      acc_l = !s.rst && s.lv && rl;

      if (s.rst) begin
         aq.delete(); lq.delete(); m_prio = 1'b1; m_cdb = zero_cdb();
      end else if (s.flush) begin
         aq.delete(); lq.delete(); m_cdb = zero_cdb();
      end else begin
         has_a = (aq.size() != 0);
         has_l = (lq.size() != 0);
         if (has_a || has_l) begin
            g = (has_a && has_l) ? m_prio : has_l;
            e = g ? lq.pop_front() : aq.pop_front();
            m_cdb.v = 1'b1; m_cdb.e = e; m_cdb.src = g;
            m_prio = !g;
         end else begin
            m_cdb = zero_cdb();
         end
         if (acc_a) aq.push_back(s.a);
         if (acc_l) begin
            e = s.l; e.addr = '0; e.br = 1'b0;
            lq.push_back(e);
         end
      end

      @(posedge clk);
      @(negedge clk);
      cyc++;
      check("cdb", pack_cdb(dut_cdb()), pack_cdb(m_cdb));
      if (bus.cdb_valid) begin
         seen_rob.push_back(int'(bus.cdb_rob_id));
         seen_cyc.push_back(cyc);
      end
   endtask

   initial begin
      vec_t       tbl[$];
      stim_t      s, idle;
      cdb_t       ec;
      logic       aa, al;
      logic [1:0] rs;
      logic       a_pend, l_pend;
      ent_t       a_item, l_item;
      int         pc;

      aq.delete(); lq.delete(); m_prio = 1'b1; m_cdb = zero_cdb();
      idle = st(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
      rst = 1'b1; flush = 1'b0;
      bus.alu_valid = 1'b0; bus.alu_rob_id = '0; bus.alu_value = '0; bus.alu_addr = '0;
      bus.alu_branch_outcome = 1'b0; bus.lsb_valid = 1'b0; bus.lsb_rob_id = '0; bus.lsb_value = '0;
      @(negedge clk);

      // Reset with both valids high, then release.
      tbl.push_back(mkv(st(1, 0, 1, 3, 1, 5), 0, 2'b00, 0, 0, 0));
      tbl.push_back(mkv(st(1, 0, 1, 3, 1, 5), 0, 2'b00, 0, 0, 0));
      tbl.push_back(mkv(idle,                 1, 2'b11, 0, 0, 0));
      // Contention: ALU 1,2 vs LSB 5,6 -> LSB5, ALU1, LSB6, ALU2.
      tbl.push_back(mkv(st(0, 0, 1, 1, 1, 5), 1, 2'b11, 0, 0, 0));
      tbl.push_back(mkv(st(0, 0, 1, 2, 1, 6), 1, 2'b11, 1, 1, 5));
      tbl.push_back(mkv(idle,                 1, 2'b01, 1, 0, 1));
      tbl.push_back(mkv(idle,                 1, 2'b11, 1, 1, 6));
      tbl.push_back(mkv(idle,                 1, 2'b11, 1, 0, 2));
      tbl.push_back(mkv(idle,                 1, 2'b11, 0, 0, 0));
      // Backpressure: LSB 7,8,12,13 against a streaming ALU 0..3.
      tbl.push_back(mkv(st(0, 0, 1, 0, 1, 7),  1, 2'b11, 0, 0, 0));
      tbl.push_back(mkv(st(0, 0, 1, 1, 1, 8),  1, 2'b11, 1, 1, 7));
      tbl.push_back(mkv(st(0, 0, 1, 2, 1, 12), 1, 2'b01, 1, 0, 0));
      tbl.push_back(mkv(st(0, 0, 1, 2, 1, 13), 1, 2'b10, 1, 1, 8));
      tbl.push_back(mkv(st(0, 0, 1, 3, 1, 13), 1, 2'b01, 1, 0, 1));
      tbl.push_back(mkv(st(0, 0, 1, 3, 0, 0),  1, 2'b10, 1, 1, 12));
      tbl.push_back(mkv(idle,                  1, 2'b01, 1, 0, 2));
      tbl.push_back(mkv(idle,                  1, 2'b11, 1, 1, 13));
      tbl.push_back(mkv(idle,                  1, 2'b11, 1, 0, 3));
      tbl.push_back(mkv(idle,                  1, 2'b11, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].s, aa, al, rs);
         if (tbl[i].chk_rdy) check("tbl_ready", CDB_BITS'(rs), CDB_BITS'(tbl[i].rdy));
         ec = zero_cdb();
         if (tbl[i].ev) begin
            ec.v   = 1'b1;
            ec.src = tbl[i].esrc;
            ec.e   = tbl[i].esrc ? lsb_ent(tbl[i].erob) : alu_ent(tbl[i].erob);
         end
         check("tbl_cdb", pack_cdb(dut_cdb()), pack_cdb(ec));
      end

      // Single ALU result: two-cycle latency, one-cycle pulse.
      s = idle; s.av = 1'b1;
      s.a.rob = 4'd3; s.a.value = 32'h11; s.a.addr = 32'h80; s.a.br = 1'b1;
      cycle(s, aa, al, rs);
      cycle(idle, aa, al, rs);
      ec.v = 1'b1; ec.src = 1'b0; ec.e = s.a;
      check("single_bcast", pack_cdb(dut_cdb()), pack_cdb(ec));
      cycle(idle, aa, al, rs);
      check("single_pulse", CDB_BITS'(bus.cdb_valid), CDB_BITS'(0));

      // Flush with both FIFOs occupied.
      cycle(st(0, 0, 1, 4, 1, 6), aa, al, rs);
      cycle(st(0, 0, 1, 5, 1, 7), aa, al, rs);
      cycle(st(0, 1, 1, 10, 1, 11), aa, al, rs);
      check("flush_ready", CDB_BITS'(rs), CDB_BITS'(2'b00));
      check("flush_cdb_valid", CDB_BITS'(bus.cdb_valid), CDB_BITS'(0));
      seen_rob.delete(); seen_cyc.delete();
      cycle(idle, aa, al, rs);
      check("post_flush_ready", CDB_BITS'(rs), CDB_BITS'(2'b11));
      cycle(idle, aa, al, rs);
      cycle(st(0, 0, 1, 9, 0, 0), aa, al, rs);
      pc = cyc;
      for (int i = 0; i < 3; i++) cycle(idle, aa, al, rs);
      check("flush_seen_count", CDB_BITS'(seen_rob.size()), CDB_BITS'(1));
      if (seen_rob.size() == 1) begin
         check("flush_new_rob", CDB_BITS'(seen_rob[0]), CDB_BITS'(9));
         check("flush_new_latency", CDB_BITS'(seen_cyc[0] - pc), CDB_BITS'(1));
      end

      // Wrap-around: ten back-to-back ALU results, no gaps.
      seen_rob.delete(); seen_cyc.delete();
      for (int i = 0; i < 10; i++) cycle(st(0, 0, 1, i, 0, 0), aa, al, rs);
      for (int i = 0; i < 3; i++) cycle(idle, aa, al, rs);
      check("wrap_count", CDB_BITS'(seen_rob.size()), CDB_BITS'(10));
      for (int i = 0; i < seen_rob.size() && i < 10; i++) begin
         check("wrap_order", CDB_BITS'(seen_rob[i]), CDB_BITS'(i));
         check("wrap_gap", CDB_BITS'(seen_cyc[i] - seen_cyc[0]), CDB_BITS'(i));
      end

      // Random traffic; producers hold an offer until it is accepted.
      a_pend = 1'b0; l_pend = 1'b0;
      a_item = alu_ent(0); l_item = lsb_ent(0);
      for (int n = 0; n < 600; n++) begin
         if (!a_pend && $urandom_range(0, 99) < 60) begin
            a_pend = 1'b1;
            a_item.rob = ROB_W'($urandom_range(0, 15)); a_item.value = $urandom;
            a_item.addr = $urandom; a_item.br = 1'($urandom_range(0, 1));
         end
         if (!l_pend && $urandom_range(0, 99) < 60) begin
            l_pend = 1'b1;
            l_item.rob = ROB_W'($urandom_range(0, 15)); l_item.value = $urandom;
            l_item.addr = $urandom; l_item.br = 1'($urandom_range(0, 1));
         end
         s.rst   = ($urandom_range(0, 149) == 0);
         s.flush = ($urandom_range(0, 24) == 0);
         s.av = a_pend; s.a = a_item;
         s.lv = l_pend; s.l = l_item;
         cycle(s, aa, al, rs);
         if (aa) a_pend = 1'b0;
         if (al) l_pend = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
